// File: rtl/rv32_pkg.sv
// rv32_pkg: shared register-file geometry and scoreboard counter type
package rv32_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    typedef logic [1:0] sb_cnt_t;
endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: in-flight long-latency write counter for one architectural register
module hazard_sb_entry
    import rv32_pkg::*;
#(
    parameter int MAX = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic inc_i,
    input  logic wb_i,
    output logic pending_o,
    output logic eff_pend_o,
    output logic at_max_o,
    output logic orphan_o
);
    sb_cnt_t cnt_q;
    logic dec;

    assign dec = wb_i && cnt_q != '0;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else if (flush_i) cnt_q <= '0;
        else if (inc_i && !dec) cnt_q <= cnt_q + 1'b1;
        else if (dec && !inc_i) cnt_q <= cnt_q - 1'b1;

    assign pending_o = cnt_q != '0;
    // The last outstanding writeback releases its consumers in the same cycle.
    assign eff_pend_o = pending_o && !(wb_i && cnt_q == sb_cnt_t'(1));
    assign at_max_o = cnt_q == sb_cnt_t'(MAX);
    assign orphan_o = wb_i && cnt_q == '0;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q <= sb_cnt_t'(MAX) && !(inc_i && !dec && !flush_i && at_max_o));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (cnt_q == '0 && !inc_i) |=> cnt_q == '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stalls decode on RAW/WAW hazards against in-flight long-latency writers
module hazard_scoreboard
    import rv32_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_long_lat_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    output logic                  stall_o,
    output logic                  rs1_pending_o,
    output logic                  rs2_pending_o,
    output logic [NUM_REGS-1:0]   pending_mask_o,
    output logic                  busy_o,
    output logic                  err_o
);
    logic [NUM_REGS-1:0] eff_pend, at_max, orphan;
    logic waw, fire;

    assign pending_mask_o[0] = 1'b0;
    assign eff_pend[0] = 1'b0;
    assign at_max[0] = 1'b0;
    assign orphan[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        hazard_sb_entry #(.MAX(MAX_OUTSTANDING)) u_entry (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (flush_i),
            .inc_i      (fire && id_rd_addr_i == REG_ADDR_W'(r)),
            .wb_i       (wb_valid_i && wb_rd_i == REG_ADDR_W'(r)),
            .pending_o  (pending_mask_o[r]),
            .eff_pend_o (eff_pend[r]),
            .at_max_o   (at_max[r]),
            .orphan_o   (orphan[r])
        );
    end

    assign rs1_pending_o = id_valid_i && id_rs1_used_i && id_rs1_addr_i != '0 && eff_pend[id_rs1_addr_i];
    assign rs2_pending_o = id_valid_i && id_rs2_used_i && id_rs2_addr_i != '0 && eff_pend[id_rs2_addr_i];
    // Short writers must not overtake a pending long write; long writers stop at saturation.
    assign waw = id_valid_i && id_reg_write_i && id_rd_addr_i != '0 &&
                 (id_long_lat_i ? at_max[id_rd_addr_i] : eff_pend[id_rd_addr_i]);
    assign stall_o = rs1_pending_o || rs2_pending_o || waw;
    assign fire = id_valid_i && !stall_o && id_reg_write_i && id_long_lat_i && id_rd_addr_i != '0;
    assign busy_o = |pending_mask_o;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) err_o <= 1'b0;
        else if (|orphan) err_o <= 1'b1;
endmodule
